// File: rtl/array_mem_arbiter.sv
// ---------------------------------------------------------------------------
// array_mem_arbiter
//
// Shares one synchronous-write / combinational-read memory array among NREQ
// requesters. At most one beat is granted per cycle. The grant drives the
// array's write and read ports directly. Read data is captured into a
// registered response, so the array's combinational read path ends here.
//
// Arbitration is round-robin, starting the search just after the last
// granted requester. A requester can hold the grant across beats with
// req_lock (burst lock).
//
// Optional feature macro: ARRAY_MEM_ARB_FIXED_PRIO_EN
//   defined     -> fixed priority, lowest index wins, last_grant is not kept
//   not defined -> round-robin (default)
//
// Handshake: a beat on requester i completes in the cycle where
// req_valid[i] & req_ready[i] is high. A requester keeps its req_* inputs
// stable while req_valid[i]=1 and req_ready[i]=0. req_ready is combinational.
// It is one-hot for the winner, or all zero when nothing is requested or
// rst is high.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   req_valid      per-requester access request
//   req_we         per-requester 1 = write, 0 = read
//   req_lock       per-requester: keep the grant after this beat
//   req_addr       packed addresses, requester i at [i*ADDR +: ADDR]
//   req_wdata      packed write data, requester i at [i*WIDTH +: WIDTH]
//   req_ready      one-hot grant (combinational)
//   rsp_valid      one-hot read response, 1 cycle after the read grant
//   rsp_data       registered read data
//   mem_write_en   array write enable
//   mem_write_addr array write address
//   mem_write_data array write data
//   mem_read_addr  array read address
//   mem_read_data  array read data (combinational from mem_read_addr)
// ---------------------------------------------------------------------------
module array_mem_arbiter #(
    parameter integer WIDTH = 8,
    parameter integer DEPTH = 16,
    parameter integer ADDR  = clog2(DEPTH),
    parameter integer NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ-1:0]         req_lock,
    input  logic [NREQ*ADDR-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    mem_write_en,
    output logic [ADDR-1:0]         mem_write_addr,
    output logic [WIDTH-1:0]        mem_write_data,
    output logic [ADDR-1:0]         mem_read_addr,
    input  logic [WIDTH-1:0]        mem_read_data
);

    // Ceiling log2, usable in constant expressions.
    function automatic integer clog2(input integer value);
        integer v;
        begin
            v = value - 1;
            for (clog2 = 0; v > 0; clog2 = clog2 + 1)
                v = v >> 1;
        end
    endfunction

    localparam integer IDXW = clog2(NREQ);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic            lock_active;
    logic [IDXW-1:0] lock_owner;
`ifndef ARRAY_MEM_ARB_FIXED_PRIO_EN
    logic [IDXW-1:0] last_grant;
`endif

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
    logic            grant;
    logic [IDXW-1:0] winner;
    logic [IDXW-1:0] search_base;
    logic [IDXW-1:0] cand_idx;
    integer          cand;

    always_comb begin
        grant    = 1'b0;
        winner   = '0;
        cand     = 0;
        cand_idx = '0;
`ifdef ARRAY_MEM_ARB_FIXED_PRIO_EN
        search_base = '0;
`else
        // Start just after the last grant, wrapping for any NREQ.
        search_base = (last_grant == IDXW'(NREQ - 1)) ? '0 : last_grant + 1'b1;
`endif
        if (lock_active && req_valid[lock_owner]) begin
            grant  = 1'b1;
            winner = lock_owner;
        end else begin
            // The first hit in search order wins; later hits are ignored.
            for (int k = 0; k < NREQ; k++) begin
                cand = integer'(search_base) + k;
                if (cand >= NREQ)
                    cand = cand - NREQ;
                cand_idx = IDXW'(cand);
                if (!grant && req_valid[cand_idx]) begin
                    grant  = 1'b1;
                    winner = cand_idx;
                end
            end
        end
        // Nothing is granted while reset is held.
        if (rst)
            grant = 1'b0;
    end

    logic grant_rd;
    assign grant_rd = grant && !req_we[winner];

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[winner] = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Memory port drive
    // -----------------------------------------------------------------------
    logic [IDXW-1:0] rd_idx;

`ifdef ARRAY_MEM_ARB_FIXED_PRIO_EN
    assign rd_idx = winner;
`else
    // With no read grant, the read port follows the last granted requester.
    assign rd_idx = grant_rd ? winner : last_grant;
`endif

    assign mem_write_en   = grant && req_we[winner];
    assign mem_write_addr = req_addr[integer'(winner)*ADDR +: ADDR];
    assign mem_write_data = req_wdata[integer'(winner)*WIDTH +: WIDTH];
    assign mem_read_addr  = req_addr[integer'(rd_idx)*ADDR +: ADDR];

    // -----------------------------------------------------------------------
    // Sequential state: pointer, lock and read response
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifndef ARRAY_MEM_ARB_FIXED_PRIO_EN
            last_grant  <= IDXW'(NREQ - 1);
`endif
            lock_active <= 1'b0;
            lock_owner  <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
        end else begin
            // A lock lasts only while each granted beat asks for it. If the
            // owner drops req_valid, the round-robin winner takes this cycle,
            // and the lock moves only if that winner also asks for it.
            lock_active <= grant && req_lock[winner];
            if (grant) begin
`ifndef ARRAY_MEM_ARB_FIXED_PRIO_EN
                last_grant <= winner;
`endif
                lock_owner <= winner;
            end
            if (grant_rd) begin
                rsp_valid <= req_ready;
                rsp_data  <= mem_read_data;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

endmodule

// File: doc/array_mem_arbiter.md
# array_mem_arbiter

Round-robin arbiter that shares one synchronous-write / combinational-read memory array among NREQ requesters. It grants at most one access per cycle and drives the memory's write and read ports directly. Read data is returned through a registered response path, so the combinational read path ends inside this block. The block sits between the requester agents (DMA, CPU port, debug port) and the array instance.

## Interface
- WIDTH, 8: data word width.
- DEPTH, 16: memory depth in words.
- ADDR, clog2(DEPTH): address width, computed with the in-module Verilog-2001 clog2 function.
- NREQ, 4: number of requesters (2..8).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester access request.
- req_we  input  NREQ  1 = write, 0 = read.
- req_lock  input  NREQ  hold the grant after this beat (burst lock).
- req_addr  input  NREQ*ADDR  packed addresses; requester i occupies [i*ADDR +: ADDR].
- req_wdata  input  NREQ*WIDTH  packed write data; requester i occupies [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot grant, combinational; a beat completes when req_valid[i] & req_ready[i].
- rsp_valid  output  NREQ  one-hot, registered; pulses 1 cycle after a granted read.
- rsp_data  output  WIDTH  registered read data.
- mem_write_en  output  1  to the array write_en.
- mem_write_addr  output  ADDR  to the array write_addr.
- mem_write_data  output  WIDTH  to the array write_data.
- mem_read_addr  output  ADDR  to the array read_addr.
- mem_read_data  input  WIDTH  from the array read_data.

## Operation
- State: last_grant pointer (clog2(NREQ) bits), lock_active flag, lock_owner index, rsp_valid and rsp_data registers.
- Winner selection per cycle:
  - If lock_active and req_valid[lock_owner] are both set, the owner wins.
  - Otherwise the first requester with req_valid set wins, searching from last_grant+1 modulo NREQ.
  - req_ready is one-hot for the winner, or all zero when no request is pending.
- Granted write: mem_write_en=1, mem_write_addr/mem_write_data taken from the winner. The array stores the word at the next edge.
- Granted read: mem_read_addr taken from the winner, mem_write_en=0. At the edge, rsp_data <= mem_read_data and rsp_valid <= onehot(winner).
- No read grant: mem_read_addr = req_addr of the last_grant requester. rsp_valid <= 0 and rsp_data holds its value.
- last_grant <= winner on every grant, and holds its value when there is no grant.
- Lock handling:
  - lock_active sets, with lock_owner = winner, when the granted beat has req_lock[winner]=1.
  - lock_active clears when the owner's granted beat has req_lock=0, or when the owner drops req_valid. In that cycle normal round-robin arbitration applies.
- Read-after-write to the same address in consecutive grants returns the new data, because the write lands at the first edge.
- Only one access per cycle, so there are no write/read collisions.
- Reset (asynchronous, effective immediately):
  - last_grant = NREQ-1, so requester 0 is first.
  - lock_active=0, rsp_valid=0, rsp_data=0.
  - req_ready and mem_write_en are forced to 0 while rst=1.
- Reset during an outstanding read: the response is dropped and rsp_valid stays 0. Reset does not clear memory contents.

## Timing
- Grant latency: 0 cycles; req_ready is combinational from req_valid and state.
- Write latency: data is visible at the array output 1 edge after the grant.
- Read latency: rsp_valid/rsp_data are asserted exactly 1 cycle after the grant. Back-to-back reads produce a response every cycle.
- Requesters hold req_* stable while req_valid=1 and req_ready=0.
- Throughput: 1 beat/cycle. Fairness: every requester is granted within NREQ grants when no lock is active.

## Configuration
- ARRAY_MEM_ARB_FIXED_PRIO_EN defined: the priority search always starts at requester 0 (lowest index wins), and last_grant is unused. Lock behaviour is unchanged.
- Not defined: round-robin as described in Operation (default).

## Test plan
- Reset then idle: rst=1 -> req_ready=0, rsp_valid=0, rsp_data=0, mem_write_en=0; after release with no requests, all outputs stay 0.
- Write then read: req0 writes 0xA5 to address 3; next cycle req0 reads address 3 -> rsp_valid=4'b0001 and rsp_data=0xA5 one cycle after the read grant.
- Round-robin: all 4 requesters hold reads continuously -> grant order 0,1,2,3,0 and rsp_valid follows the same order 1 cycle delayed.
- Lock: req2 issues 3 beats with req_lock=1,1,0 while req0 also requests -> req2 is granted 3 consecutive cycles, then req0.
- Reset mid-read: rst asserted in the cycle a read is granted -> no rsp_valid pulse; after release, requester 0 is granted first.
- Fixed priority with ARRAY_MEM_ARB_FIXED_PRIO_EN: req0 and req1 both valid for 3 cycles -> req0 granted all 3 cycles.
